// File: rtl/temp_entry_seq_pkg.sv
// Shared encodings and defaults for the temperature entry front end.
// Top-level option: define ENTRY_TIMEOUT_EN to build the partial-entry abort timer.
package temp_entry_seq_pkg;

  // The state encoding doubles as the published digit index.
  typedef enum logic [1:0] {
    S_ONES = 2'd0,
    S_TENS = 2'd1,
    S_HUNS = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [3:0] BCD_MAX = 4'd9;

  localparam int DB_CYCLES_DEF      = 500000;
  localparam int TIMEOUT_CYCLES_DEF = 250000000;

  function automatic logic bcd_ok(input logic [3:0] d);
    return (d <= BCD_MAX);
  endfunction

endpackage

// File: rtl/temp_entry_seq_key_debounce.sv
// Key conditioning: 2-flop synchroniser, stability-count debouncer and press-edge detector.
// pressed_pulse is high for one cycle when the debounced key goes released->pressed.
module key_debounce
  import temp_entry_seq_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n,
  output logic pressed_pulse
);

  localparam int CW = $clog2(DB_CYCLES + 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_level;
  logic          r_press;
  logic [CW-1:0] r_cnt;

  logic w_differs;
  logic w_flip;

  assign w_differs = r_sync2 ^ r_level;
  assign w_flip    = w_differs && (r_cnt == CW'(DB_CYCLES - 1));

  // Level is active-low like the key: 1 = released. Any agreement restarts the count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_level <= 1'b1;
      r_cnt   <= '0;
      r_press <= 1'b0;
    end else begin
      r_sync1 <= key_n;
      r_sync2 <= r_sync1;
      r_press <= w_flip && r_level;
      if (!w_differs) begin
        r_cnt <= '0;
      end else if (w_flip) begin
        r_cnt   <= '0;
        r_level <= r_sync2;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign pressed_pulse = r_press;

endmodule

// File: rtl/temp_entry_seq.sv
// Temperature entry sequencer: captures ones, tens, hundreds digits (plus sign) on debounced presses.
// Optional macro ENTRY_TIMEOUT_EN adds an idle timer that aborts a partial entry.
module temp_entry_seq
  import temp_entry_seq_pkg::*;
#(
  parameter int DB_CYCLES      = DB_CYCLES_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_n,
  input  logic [3:0] sw_bcd,
  input  logic       sign_sw,
  output logic [1:0] digit_idx,
  output logic [3:0] ones_o,
  output logic [3:0] tens_o,
  output logic [3:0] huns_o,
  output logic       sign_o,
  output logic       value_valid,
  output logic       entry_err,
  output logic       timeout
);

  state_t     r_state;
  state_t     w_state_next;
  logic [3:0] r_ones;
  logic [3:0] r_tens;
  logic [3:0] r_huns;
  logic       r_sign;
  logic       r_valid;
  logic       r_err;
  logic       r_timeout;

  logic w_press;
  logic w_expire;
  logic w_ld_ones;
  logic w_ld_tens;
  logic w_ld_huns;
  logic w_clear;
  logic w_err;
  logic w_valid;
  logic w_abort;

  key_debounce #(
    .DB_CYCLES (DB_CYCLES)
  ) u_key_debounce (
    .clk           (clk),
    .rst           (rst),
    .key_n         (key_n),
    .pressed_pulse (w_press)
  );

`ifdef ENTRY_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] r_idle;
  logic          w_idle_run;

  assign w_idle_run = (r_state == S_TENS) || (r_state == S_HUNS);
  assign w_expire   = w_idle_run && (r_idle == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_idle <= '0;
    end else if (w_press || !w_idle_run || w_expire) begin
      r_idle <= '0;
    end else begin
      r_idle <= r_idle + 1'b1;
    end
  end
`else
  assign w_expire = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_ONES;
    end else begin
      r_state <= w_state_next;
    end
  end

  // A press always takes priority over a coinciding timeout expiry.
  always_comb begin
    w_state_next = r_state;
    w_ld_ones    = 1'b0;
    w_ld_tens    = 1'b0;
    w_ld_huns    = 1'b0;
    w_clear      = 1'b0;
    w_err        = 1'b0;
    w_valid      = 1'b0;
    w_abort      = 1'b0;
    if (w_press) begin
      if (r_state == S_DONE) begin
        w_clear      = 1'b1;
        w_state_next = S_ONES;
      end else if (!bcd_ok(sw_bcd)) begin
        w_err = 1'b1;
      end else begin
        case (r_state)
          S_ONES: begin
            w_ld_ones    = 1'b1;
            w_state_next = S_TENS;
          end
          S_TENS: begin
            w_ld_tens    = 1'b1;
            w_state_next = S_HUNS;
          end
          S_HUNS: begin
            w_ld_huns    = 1'b1;
            w_valid      = 1'b1;
            w_state_next = S_DONE;
          end
          default: begin
            w_state_next = r_state;
          end
        endcase
      end
    end else if (w_expire) begin
      w_clear      = 1'b1;
      w_abort      = 1'b1;
      w_state_next = S_ONES;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ones    <= 4'd0;
      r_tens    <= 4'd0;
      r_huns    <= 4'd0;
      r_sign    <= 1'b0;
      r_valid   <= 1'b0;
      r_err     <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_valid   <= w_valid;
      r_err     <= w_err;
      r_timeout <= w_abort;
      if (w_clear) begin
        r_ones <= 4'd0;
        r_tens <= 4'd0;
        r_huns <= 4'd0;
        r_sign <= 1'b0;
      end
      if (w_ld_ones) r_ones <= sw_bcd;
      if (w_ld_tens) r_tens <= sw_bcd;
      if (w_ld_huns) begin
        r_huns <= sw_bcd;
        r_sign <= sign_sw;
      end
    end
  end

  assign digit_idx   = r_state;
  assign ones_o      = r_ones;
  assign tens_o      = r_tens;
  assign huns_o      = r_huns;
  assign sign_o      = r_sign;
  assign value_valid = r_valid;
  assign entry_err   = r_err;
  assign timeout     = r_timeout;

endmodule

// File: tb/tb_temp_entry_seq.sv
// Directed bench for temp_entry_seq with DB_CYCLES=4 and TIMEOUT_CYCLES=20.
// Expectations for the idle-abort case follow ENTRY_TIMEOUT_EN.
module tb_temp_entry_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       key_n = 1'b1;
  logic [3:0] sw_bcd = 4'd0;
  logic       sign_sw = 1'b0;
  logic [1:0] digit_idx;
  logic [3:0] ones_o;
  logic [3:0] tens_o;
  logic [3:0] huns_o;
  logic       sign_o;
  logic       value_valid;
  logic       entry_err;
  logic       timeout;

  int n_checks = 0;
  int n_fail   = 0;
  int vv_cnt   = 0;
  int vv_bad   = 0;
  int err_cnt  = 0;
  int to_cnt   = 0;

  temp_entry_seq #(
    .DB_CYCLES      (4),
    .TIMEOUT_CYCLES (20)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .key_n       (key_n),
    .sw_bcd      (sw_bcd),
    .sign_sw     (sign_sw),
    .digit_idx   (digit_idx),
    .ones_o      (ones_o),
    .tens_o      (tens_o),
    .huns_o      (huns_o),
    .sign_o      (sign_o),
    .value_valid (value_valid),
    .entry_err   (entry_err),
    .timeout     (timeout)
  );

  always #5 clk = ~clk;

  // Pulse monitor; value_valid must only ever be seen while digit_idx reads 3.
  always @(negedge clk) begin
    if (rst) begin
      if (value_valid) begin
        vv_cnt++;
        if (digit_idx != 2'd3) vv_bad++;
      end
      if (entry_err) err_cnt++;
      if (timeout) to_cnt++;
    end
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Hold the key low long enough for one debounced press, then release and scramble the switches.
  task automatic press(input logic [3:0] d, input logic s);
    sw_bcd  = d;
    sign_sw = s;
    key_n   = 1'b0;
    wait_cycles(8);
    key_n   = 1'b1;
    sw_bcd  = 4'($urandom_range(0, 15));
    sign_sw = 1'($urandom_range(0, 1));
    wait_cycles(8);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    wait_cycles(3);
    check("rst_idx", digit_idx, 2'd0);
    check("rst_ones", ones_o, 4'd0);
    check("rst_tens", tens_o, 4'd0);
    check("rst_huns", huns_o, 4'd0);
    check("rst_sign", sign_o, 1'b0);
    check("rst_valid", value_valid, 1'b0);
    rst = 1'b1;
    wait_cycles(3);

    // Clean three-digit entry
    press(4'd3, 1'b0);
    check("t1_idx_after_ones", digit_idx, 2'd1);
    check("t1_ones_early", ones_o, 4'd3);
    press(4'd7, 1'b0);
    press(4'd1, 1'b1);
    check("t1_ones", ones_o, 4'd3);
    check("t1_tens", tens_o, 4'd7);
    check("t1_huns", huns_o, 4'd1);
    check("t1_sign", sign_o, 1'b1);
    check("t1_idx", digit_idx, 2'd3);
    check("t1_vv_cnt", vv_cnt, 1);
    wait_cycles(20);
    check("t1_hold_idx", digit_idx, 2'd3);
    check("t1_hold_huns", huns_o, 4'd1);

    // Restart from S_DONE
    press(4'd9, 1'b1);
    check("t4_ones", ones_o, 4'd0);
    check("t4_tens", tens_o, 4'd0);
    check("t4_huns", huns_o, 4'd0);
    check("t4_sign", sign_o, 1'b0);
    check("t4_idx", digit_idx, 2'd0);
    check("t4_vv_cnt", vv_cnt, 1);

    // Bouncing key, then a solid press
    sw_bcd = 4'd6;
    repeat (3) begin
      key_n = 1'b0;
      wait_cycles(2);
      key_n = 1'b1;
      wait_cycles(2);
    end
    check("t2_no_capture_idx", digit_idx, 2'd0);
    key_n = 1'b0;
    wait_cycles(10);
    key_n = 1'b1;
    wait_cycles(8);
    check("t2_idx", digit_idx, 2'd1);
    check("t2_ones", ones_o, 4'd6);

    // Invalid digit in S_TENS, then a valid one
    press(4'hC, 1'b0);
    check("t3_err_cnt", err_cnt, 1);
    check("t3_idx", digit_idx, 2'd1);
    check("t3_tens", tens_o, 4'd0);
    press(4'd5, 1'b0);
    check("t3_tens_ok", tens_o, 4'd5);
    check("t3_idx_ok", digit_idx, 2'd2);
    check("t3_err_cnt2", err_cnt, 1);

    // Asynchronous reset in S_HUNS
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    check("t5_idx", digit_idx, 2'd0);
    check("t5_ones", ones_o, 4'd0);
    check("t5_tens", tens_o, 4'd0);
    check("t5_huns", huns_o, 4'd0);
    check("t5_sign", sign_o, 1'b0);
    wait_cycles(2);
    rst = 1'b1;
    wait_cycles(2);
    check("t5_idx_rel", digit_idx, 2'd0);
    check("t5_vv_cnt", vv_cnt, 1);

    // Idle after a partial entry
    press(4'd2, 1'b0);
    wait_cycles(30);
`ifdef ENTRY_TIMEOUT_EN
    check("t6_to_cnt", to_cnt, 1);
    check("t6_ones", ones_o, 4'd0);
    check("t6_idx", digit_idx, 2'd0);
`else
    check("t6_to_cnt", to_cnt, 0);
    check("t6_ones", ones_o, 4'd2);
    check("t6_idx", digit_idx, 2'd1);
`endif

    check("vv_only_in_done", vv_bad, 0);
    check("final_vv_cnt", vv_cnt, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
